// File: rtl/mram_pkg.sv
// mram_pkg: shared widths, select-bit indices and FSM states for the MRAM front end
package mram_pkg;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int FRAME_LEN = 20;
  localparam int SEL_WR = 0;
  localparam int SEL_LB = 1;
  localparam int SEL_UB = 2;
  typedef enum logic [1:0] {SHIFT, ACCESS, SERIAL} state_t;
endpackage

// File: rtl/mram_top_module_stp_shift.sv
// stp_shift: LSB-first serial-to-parallel shift register exposing its next value
module stp_shift #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] nxt
);
  logic [W-1:0] q;
  assign nxt = en ? {din, q[W-1:1]} : q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else q <= nxt;
endmodule

// File: rtl/mram_top_module.sv
// mram_top_module: serial command front end driving an async parallel MRAM
module mram_top_module #(
  parameter int ADDR_W = mram_pkg::ADDR_W,
  parameter int DATA_W = mram_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_in,
  input  logic              addr_in,
  input  logic [2:0]        read_write_sel,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              ser_data_out,
  output logic              chip_en,
  output logic              write_en,
  output logic              out_en,
  output logic              lower_byte_en,
  output logic              upper_byte_en
);
  import mram_pkg::*;
  localparam int H = DATA_W / 2;
  state_t state, state_nx;
  logic [4:0] cnt;
  logic [2:0] sel_q;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] data_nxt, rb, p2s;
  logic last_bit, acc;
  assign last_bit = state == SHIFT && cnt == 5'(FRAME_LEN - 1);
  stp_shift #(.W(ADDR_W)) u_addr (
    .clk(clk), .rst(rst), .en(state == SHIFT), .din(addr_in), .nxt(addr_nxt)
  );
  stp_shift #(.W(DATA_W)) u_data (
    .clk(clk), .rst(rst), .en(state == SHIFT && cnt < 5'(DATA_W)), .din(data_in), .nxt(data_nxt)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= SHIFT;
      cnt      <= '0;
      sel_q    <= '0;
      addr_out <= '0;
      data_out <= '0;
      rb       <= '0;
      p2s      <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == SHIFT && !last_bit) || (state == SERIAL && cnt != 5'(DATA_W - 1)) ? cnt + 5'd1 : 5'd0;
      if (last_bit) begin
        addr_out <= addr_nxt;
        data_out <= data_nxt;
        sel_q    <= read_write_sel;
      end
      if (acc && sel_q[SEL_WR] && sel_q[SEL_LB]) rb[H-1:0] <= data_out[H-1:0];
      if (acc && sel_q[SEL_WR] && sel_q[SEL_UB]) rb[DATA_W-1:H] <= data_out[DATA_W-1:H];
      p2s <= acc ? rb & {{H{sel_q[SEL_UB]}}, {H{sel_q[SEL_LB]}}} : state == SERIAL ? p2s << 1 : p2s;
    end
  // A frame with no byte selected never leaves SHIFT, so no strobe is issued
  always_comb begin
    acc           = state == ACCESS;
    state_nx      = state == SHIFT ? (last_bit && |read_write_sel[SEL_UB:SEL_LB] ? ACCESS : SHIFT) :
                    state == ACCESS ? (sel_q[SEL_WR] ? SHIFT : SERIAL) :
                    cnt == 5'(DATA_W - 1) ? SHIFT : SERIAL;
    chip_en       = ~acc;
    write_en      = ~(acc & sel_q[SEL_WR]);
    out_en        = ~(acc & ~sel_q[SEL_WR]);
    lower_byte_en = ~(acc & sel_q[SEL_LB]);
    upper_byte_en = ~(acc & sel_q[SEL_UB]);
    ser_data_out  = state == SERIAL && p2s[DATA_W-1];
  end
endmodule

// File: tb/tb_mram_top_module.sv
// tb_mram_top_module: directed frames with a read-word scoreboard checked against serial output
module tb_mram_top_module;
  logic clk = 0, rst = 0, data_in = 0, addr_in = 0;
  logic [2:0] read_write_sel = 0;
  logic [15:0] data_out;
  logic [19:0] addr_out;
  logic ser_data_out, chip_en, write_en, out_en, lower_byte_en, upper_byte_en;
  logic [4:0] stb;
  logic [15:0] rb_m = 0;
  logic [15:0] sb[$];
  int vecs = 0, errs = 0;
  assign stb = {chip_en, write_en, out_en, lower_byte_en, upper_byte_en};

  mram_top_module dut (
    .clk(clk), .rst(rst), .data_in(data_in), .addr_in(addr_in), .read_write_sel(read_write_sel),
    .data_out(data_out), .addr_out(addr_out), .ser_data_out(ser_data_out), .chip_en(chip_en),
    .write_en(write_en), .out_en(out_en), .lower_byte_en(lower_byte_en), .upper_byte_en(upper_byte_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic frame(input logic [19:0] a, input logic [15:0] d, input logic [2:0] s);
    logic [15:0] got;
    logic [15:0] exp;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      addr_in = a[k];
      data_in = k < 16 ? d[k] : 1'($urandom);
      read_write_sel = k == 19 ? s : 3'($urandom);
    end
    @(posedge clk); #1;
    if (s[2:1] == 2'b00) begin
      chk("discard_strobes", 32'(stb), 32'h1f);
      return;
    end
    chk("addr_out", 32'(addr_out), 32'(a));
    chk("data_out", 32'(data_out), 32'(d));
    chk("access_strobes", 32'(stb), 32'({1'b0, ~s[0], s[0], ~s[1], ~s[2]}));
    if (s[0]) begin
      if (s[1]) rb_m[7:0] = d[7:0];
      if (s[2]) rb_m[15:8] = d[15:8];
      @(posedge clk); #1;
      chk("strobes_release", 32'(stb), 32'h1f);
      return;
    end
    sb.push_back(rb_m & {{8{s[2]}}, {8{s[1]}}});
    chk("ser_idle_access", 32'(ser_data_out), 32'h0);
    for (int i = 15; i >= 0; i--) begin
      @(posedge clk); #1;
      got[i] = ser_data_out;
      if (i == 15) chk("strobes_release", 32'(stb), 32'h1f);
    end
    @(posedge clk); #1;
    chk("ser_idle_after", 32'(ser_data_out), 32'h0);
    exp = sb.pop_front();
    chk("ser_word", 32'(got), 32'(exp));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", 32'(addr_out), 32'h0);
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_ser", 32'(ser_data_out), 32'h0);
    chk("rst_strobes", 32'(stb), 32'h1f);
    @(posedge clk); #2 rst = 1;
    frame(20'h00000, 16'hAAAA, 3'b111);
    frame(20'h00001, 16'hAAAA, 3'b011);
    frame(20'h00002, 16'hAAAB, 3'b101);
    frame(20'hABCDE, 16'h1357, 3'b110);
    frame(20'h12345, 16'h0F0F, 3'b010);
    frame(20'h54321, 16'hF0F0, 3'b100);
    frame(20'h0FFFF, 16'hFFFF, 3'b001);
    frame(20'hFFFFF, 16'h0000, 3'b110);
    frame(20'h3C3C3, 16'h5A5A, 3'b111);
    frame(20'h80000, 16'h0001, 3'b110);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      addr_in = 1'($urandom);
      data_in = 1'($urandom);
      read_write_sel = 3'b111;
    end
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    rb_m = 0;
    #1;
    chk("abort_addr", 32'(addr_out), 32'h0);
    chk("abort_data", 32'(data_out), 32'h0);
    chk("abort_ser", 32'(ser_data_out), 32'h0);
    chk("abort_strobes", 32'(stb), 32'h1f);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_hold_strobes", 32'(stb), 32'h1f);
    end
    @(posedge clk); #2 rst = 1;
    frame(20'h00005, 16'h1234, 3'b111);
    frame(20'h0000A, 16'h0000, 3'b110);
    frame(20'hDEAD5, 16'h9876, 3'b011);
    frame(20'h00000, 16'h0000, 3'b010);
    frame(20'h00000, 16'h0000, 3'b100);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
